button_event_controller: RTL
============================

Name: button_event_controller

Overview:
- Input-direction counterpart of the front-panel display path: converts raw, bouncing, active-low push-buttons (S1–S4) into clean debounced levels, single-cycle press/release/auto-repeat pulses, and a queued event stream with a valid/ack handshake.
- Sits between the board button pins and the core control logic, replacing ad-hoc per-button debounce flags in the top level.

Parameters:
- NUM_BUTTONS, 4, number of button inputs (index 0 = S1 … 3 = S4)
- DEBOUNCE_CYCLES, 1000000, cycles a synchronized input must differ from the stable state before the stable state flips (20 ms at 50 MHz); ≥1
- REPEAT_DELAY, 25000000, cycles from press to first repeat; 0 disables auto-repeat
- REPEAT_RATE, 5000000, cycles between subsequent repeats; ≥1
- CNT_WIDTH, 25, width of debounce and repeat counters; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE)
- FIFO_DEPTH, 4, event queue entries; power of two

Ports:
- clk  in  1  system clock (50 MHz board clock)
- reset_n  in  1  asynchronous, active-low reset
- buttons_n  in  NUM_BUTTONS  raw button pins, 0 = pressed
- pressed  out  NUM_BUTTONS  debounced level, 1 = held
- press_pulse  out  NUM_BUTTONS  1-cycle pulse on debounced press
- release_pulse  out  NUM_BUTTONS  1-cycle pulse on debounced release
- repeat_pulse  out  NUM_BUTTONS  1-cycle auto-repeat pulse
- event_valid  out  1  FIFO head valid
- event_button  out  2  button index of head event
- event_type  out  2  01 press, 10 release, 11 repeat (00 never emitted)
- event_ack  in  1  consumer pops head when event_valid && event_ack
- overflow  out  1  sticky; an event was lost

Behaviour:
- Reset, asynchronous and active-low:
  - pressed, all pulses, event_valid, overflow, counters, pending bits and FIFO pointers go to 0.
  - Synchronizer flops go to 1 (released).
  - event_button and event_type go to 0.
- Synchronizer: 2-flop synchronizer per button; internal sync = ~buttons_n after 2 edges.
- Debounce, per button:
  - If sync == pressed, counter clears.
  - Otherwise the counter increments. On the edge where counter == DEBOUNCE_CYCLES-1 and sync still differs, pressed toggles and the counter clears.
  - Any glitch back to the stable value restarts the count.
  - Latency: raw stable change to pressed change = DEBOUNCE_CYCLES+2 edges.
- Pulses:
  - press_pulse/release_pulse are registered and asserted in the same cycle pressed changes, for exactly 1 cycle.
- Auto-repeat:
  - The repeat counter clears on press and while released.
  - While pressed, the first repeat_pulse fires REPEAT_DELAY cycles after the press_pulse cycle, then every REPEAT_RATE cycles.
  - Release stops repeats immediately; no repeat in the release cycle.
  - With REPEAT_DELAY = 0, repeat_pulse is never asserted.
- Pending bits:
  - Each pulse sets a per-button, per-type pending bit. A pending bit is cleared when its event is pushed.
  - A pulse arriving while the same bit is still set sets overflow; that event is lost.
- Arbiter:
  - One push per cycle; lowest button index first; within a button, press > repeat > release.
  - A push is permitted when FIFO not full, or when full and a pop occurs in the same cycle.
  - Pending bits wait and are not dropped while the FIFO is full.
  - A pulse's event can be pushed at the earliest on the edge after the pulse; it appears on event_valid one cycle after the push.
- FIFO:
  - event_valid = count != 0; head fields are stable while valid && !ack.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop: count unchanged. Pop when empty is ignored.
- overflow clears only on reset.
- Reset mid-debounce or mid-press: all progress discarded. A button still held after reset release produces a fresh press after DEBOUNCE_CYCLES+2 edges.

Test Plan:
All tests use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3, FIFO_DEPTH=4, event_ack=1 unless stated.
1. buttons_n[1] driven 0 at edge 0 and held → pressed[1]=1 and press_pulse[1]=1 (1 cycle) at edge 6; event_valid with button=1, type=01 at edge 8. Release at edge 20 → release_pulse[1] at edge 26; event type=10 follows.
2. buttons_n[0] toggled every 2 cycles for 20 cycles, then held 1 → pressed stays 0, no pulses, no events.
3. buttons_n[2] held 0 for 40 cycles → press at edge 6; repeat_pulse[2] at edges 16, 19, 22, …; matching type=11 events. Release stops repeats with no extra repeat.
4. buttons_n[0] and buttons_n[3] pressed on the same edge, event_ack=0 → FIFO holds (0,01) then (3,01). Raising ack pops them in that order, one per cycle; event_valid drops after the second pop.
5. event_ack=0:
   - Generate 4 press events, then a 5th press on a button whose event is already pending → FIFO full, event_valid held, head unchanged.
   - The 5th event waits pending; a second pulse of that same type sets overflow=1.
   - Ack drains FIFO and the pending event enters it.
6. Assert reset_n=0 for 1 cycle at debounce count 2 of a held button → all outputs 0 immediately (asynchronous). Press re-detected 6 edges after reset release; overflow stays 0.

Source files
------------

// File: rtl/button_event_controller.sv
// rtl/button_event_controller.sv - debounced push-button levels, press/release/repeat pulses and a queued event stream
module button_event_controller #(
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000,
  parameter int CNT_WIDTH       = 25,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_BUTTONS-1:0] buttons_n,
  output logic [NUM_BUTTONS-1:0] pressed,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic [NUM_BUTTONS-1:0] release_pulse,
  output logic [NUM_BUTTONS-1:0] repeat_pulse,
  output logic                   event_valid,
  output logic [1:0]             event_button,
  output logic [1:0]             event_type,
  input  logic                   event_ack,
  output logic                   overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] DB_LAST    = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] DELAY_LAST = CNT_WIDTH'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [CNT_WIDTH-1:0] RATE_LAST  = CNT_WIDTH'(REPEAT_RATE - 1);
  localparam logic RPT_EN = (REPEAT_DELAY != 0);

  localparam logic [1:0] TYPE_PRESS   = 2'b01;
  localparam logic [1:0] TYPE_RELEASE = 2'b10;
  localparam logic [1:0] TYPE_REPEAT  = 2'b11;

  // Per-button front end: synchronizer, debounce and auto-repeat
  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
    logic [1:0]           sync_ff;
    logic                 sync_lvl;
    logic                 stable_q;
    logic [CNT_WIDTH-1:0] db_cnt;
    logic                 flip;
    logic                 press_q;
    logic                 rel_q;
    logic                 rpt_q;
    logic [CNT_WIDTH-1:0] rpt_cnt;
    logic [CNT_WIDTH-1:0] rpt_last;
    logic                 rpt_phase;

    assign sync_lvl = ~sync_ff[1];
    assign flip     = (sync_lvl != stable_q) && (db_cnt == DB_LAST);
    assign rpt_last = rpt_phase ? RATE_LAST : DELAY_LAST;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync_ff   <= 2'b11;
        stable_q  <= 1'b0;
        db_cnt    <= '0;
        press_q   <= 1'b0;
        rel_q     <= 1'b0;
        rpt_q     <= 1'b0;
        rpt_cnt   <= '0;
        rpt_phase <= 1'b0;
      end else begin
        sync_ff <= {sync_ff[0], buttons_n[i]};
        press_q <= flip && !stable_q;
        rel_q   <= flip && stable_q;
        rpt_q   <= 1'b0;

        if (sync_lvl == stable_q) begin
          db_cnt <= '0;
        end else if (flip) begin
          db_cnt   <= '0;
          stable_q <= ~stable_q;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end

        // A flip edge is either the press (restart) or the release (no repeat allowed)
        if (!stable_q || flip || !RPT_EN) begin
          rpt_cnt   <= '0;
          rpt_phase <= 1'b0;
        end else if (rpt_cnt == rpt_last) begin
          rpt_q     <= 1'b1;
          rpt_cnt   <= '0;
          rpt_phase <= 1'b1;
        end else begin
          rpt_cnt <= rpt_cnt + 1'b1;
        end
      end
    end

    assign pressed[i]       = stable_q;
    assign press_pulse[i]   = press_q;
    assign release_pulse[i] = rel_q;
    assign repeat_pulse[i]  = rpt_q;
  end

  logic [NUM_BUTTONS-1:0] pend_press;
  logic [NUM_BUTTONS-1:0] pend_rel;
  logic [NUM_BUTTONS-1:0] pend_rpt;
  logic [NUM_BUTTONS-1:0] sel_press;
  logic [NUM_BUTTONS-1:0] sel_rel;
  logic [NUM_BUTTONS-1:0] sel_rpt;
  logic [NUM_BUTTONS-1:0] clr_press;
  logic [NUM_BUTTONS-1:0] clr_rel;
  logic [NUM_BUTTONS-1:0] clr_rpt;
  logic                   sel_valid;
  logic [1:0]             sel_btn;
  logic [1:0]             sel_type;

  // Lowest button wins; within a button press beats repeat beats release
  always_comb begin
    sel_valid = 1'b0;
    sel_btn   = 2'b00;
    sel_type  = 2'b00;
    sel_press = '0;
    sel_rel   = '0;
    sel_rpt   = '0;
    for (int b = 0; b < NUM_BUTTONS; b++) begin
      if (!sel_valid) begin
        if (pend_press[b]) begin
          sel_valid    = 1'b1;
          sel_btn      = 2'(b);
          sel_type     = TYPE_PRESS;
          sel_press[b] = 1'b1;
        end else if (pend_rpt[b]) begin
          sel_valid  = 1'b1;
          sel_btn    = 2'(b);
          sel_type   = TYPE_REPEAT;
          sel_rpt[b] = 1'b1;
        end else if (pend_rel[b]) begin
          sel_valid  = 1'b1;
          sel_btn    = 2'(b);
          sel_type   = TYPE_RELEASE;
          sel_rel[b] = 1'b1;
        end
      end
    end
  end

  logic [3:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          pop;
  logic          push;
  logic          full;

  assign full        = (count == FULL_CNT);
  assign event_valid = (count != '0);
  assign pop         = event_valid && event_ack;
  assign push        = sel_valid && (!full || pop);
  assign {event_button, event_type} = mem[rd_ptr];

  assign clr_press = push ? sel_press : '0;
  assign clr_rel   = push ? sel_rel   : '0;
  assign clr_rpt   = push ? sel_rpt   : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_press <= '0;
      pend_rel   <= '0;
      pend_rpt   <= '0;
      overflow   <= 1'b0;
    end else begin
      pend_press <= (pend_press & ~clr_press) | press_pulse;
      pend_rel   <= (pend_rel & ~clr_rel) | release_pulse;
      pend_rpt   <= (pend_rpt & ~clr_rpt) | repeat_pulse;
      // A bit still set after this edge's push means the new pulse collides
      if (|(press_pulse & pend_press & ~clr_press) ||
          |(release_pulse & pend_rel & ~clr_rel) ||
          |(repeat_pulse & pend_rpt & ~clr_rpt)) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < FIFO_DEPTH; k++) mem[k] <= 4'b0000;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {sel_btn, sel_type};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
